rs_issue_select: RTL and testbench

- Issue stage directly downstream of the reservation-station entries.
- Each cycle it picks one ready RS entry by round-robin priority.
- Operands flagged as arriving on this cycle's CDB are replaced with the CDB value.
- The chosen entry is cleared, and the issued packet is registered into the IS/EX pipeline register for the execute stage, with a stall handshake from execute.

---
 rtl/rs_issue_select_pkg.sv | 47 ++++
 rtl/rs_issue_select_rr_arbiter.sv | 36 +++
 rtl/rs_issue_select.sv | 95 +++++++++
 tb/tb_rs_issue_select.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_select_pkg.sv
// Shared types for the issue stage: operand-source flags, IS/EX packet, CDB packet, NOP defaults.
package rs_issue_select_pkg;

  typedef enum logic [1:0] {TAGTAG, TAGCDB, CDBTAG, CDBCDB} flag_e;
  typedef enum logic [1:0] {OPA_IS_RS1, OPA_IS_NPC, OPA_IS_PC, OPA_IS_ZERO} opa_sel_e;
  typedef enum logic [1:0] {OPB_IS_RS2, OPB_IS_I_IMM, OPB_IS_S_IMM, OPB_IS_B_IMM} opb_sel_e;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, ALU_XOR} alu_func_e;
  typedef enum logic [1:0] {ALU, MULT, LOAD, STORE} channel_e;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    opa_sel_e    opa_select;
    opb_sel_e    opb_select;
    logic [4:0]  dest_reg_idx;
    alu_func_e   alu_func;
    channel_e    channel;
    logic [2:0]  mem_size;
    logic        is_zeroreg;
    logic [5:0]  rob_tag;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
  } is_packet_t;

  typedef struct packed {
    logic [5:0]  reg_tag;
    logic [31:0] reg_value;
  } cdb_packet_t;

  function automatic is_packet_t nop_packet();
    is_packet_t p;
    p              = '0;
    p.inst         = NOP;
    p.opa_select   = OPA_IS_RS1;
    p.opb_select   = OPB_IS_RS2;
    p.dest_reg_idx = ZERO_REG;
    p.alu_func     = ALU_ADD;
    p.is_zeroreg   = 1'b1;
    p.channel      = ALU;
    p.mem_size     = 3'b111;
    return p;
  endfunction

endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// Round-robin arbiter: doubles the request vector, rotates it by ptr, priority-encodes the lowest set bit.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;

  assign dbl = {req, req};

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = dbl[i + int'(ptr)];
  end

  // Descending scan so the lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign any       = |req;
  assign grant_idx = ptr + off;
  assign grant     = any ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/rs_issue_select.sv
// Issue select: round-robin pick of a ready RS entry, CDB operand forwarding, IS/EX register.
// Optional performance counters enabled by ISSUE_PERF_CNT_EN.
module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int RS_LEN = 8,
  parameter int IDX_W  = $clog2(RS_LEN)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  is_packet_t [RS_LEN-1:0]  entry_packet_in,
  input  logic [RS_LEN-1:0]        entry_ready,
  input  flag_e [RS_LEN-1:0]       entry_flag,
  input  cdb_packet_t              cdb_packet_in,
  input  logic                     ex_stall,
  output logic [RS_LEN-1:0]        clear,
  output logic                     issue_fire,
  output logic [IDX_W-1:0]         issue_idx,
  output is_packet_t               is_packet_out,
  output logic                     is_valid
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  // Handshake: execute takes is_packet_out on any edge where is_valid && !ex_stall;
  // a new packet may be loaded whenever the register is empty or being drained.
  logic              can_accept;
  logic [IDX_W-1:0]  rr_ptr;
  logic [RS_LEN-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_ready;
  flag_e             sel_flag;
  is_packet_t        fwd_packet;
  logic              unused_tag;

  rr_arbiter #(.N(RS_LEN), .IW(IDX_W)) u_arb (
    .req       (entry_ready),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_ready)
  );

  assign can_accept = !is_valid || !ex_stall;
  assign issue_fire = can_accept && any_ready && !squash;
  assign issue_idx  = issue_fire ? grant_idx : '0;
  assign clear      = issue_fire ? grant : '0;
  assign sel_flag   = entry_flag[grant_idx];
  assign unused_tag = ^cdb_packet_in.reg_tag;

  always_comb begin
    fwd_packet = entry_packet_in[grant_idx];
    case (sel_flag)
      CDBTAG: fwd_packet.rs1_value = cdb_packet_in.reg_value;
      TAGCDB: fwd_packet.rs2_value = cdb_packet_in.reg_value;
      CDBCDB: begin
        fwd_packet.rs1_value = cdb_packet_in.reg_value;
        fwd_packet.rs2_value = cdb_packet_in.reg_value;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      is_valid      <= 1'b0;
      is_packet_out <= nop_packet();
      rr_ptr        <= '0;
    end else if (issue_fire) begin
      is_valid      <= 1'b1;
      is_packet_out <= fwd_packet;
      rr_ptr        <= grant_idx + IDX_W'(1);
    end else if (can_accept) begin
      is_valid      <= 1'b0;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Squash deliberately leaves the counters running.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue_fire) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (is_valid && ex_stall && any_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: selection, rotation, forwarding, stall, squash, optional counters.
module tb_rs_issue_select;
  import rs_issue_select_pkg::*;

  logic              clock = 1'b0;
  logic              reset, squash, ex_stall;
  is_packet_t [7:0]  entry_packet_in;
  logic [7:0]        entry_ready;
  flag_e [7:0]       entry_flag;
  cdb_packet_t       cdb_packet_in;
  logic [7:0]        clear;
  logic              issue_fire;
  logic [2:0]        issue_idx;
  is_packet_t        is_packet_out;
  logic              is_valid;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]       perf_issue_cnt, perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rs_issue_select #(.RS_LEN(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .entry_packet_in (entry_packet_in),
    .entry_ready     (entry_ready),
    .entry_flag      (entry_flag),
    .cdb_packet_in   (cdb_packet_in),
    .ex_stall        (ex_stall),
    .clear           (clear),
    .issue_fire      (issue_fire),
    .issue_idx       (issue_idx),
    .is_packet_out   (is_packet_out),
    .is_valid        (is_valid)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issue_cnt  (perf_issue_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic is_packet_t mk_pkt(int i);
    is_packet_t p;
    p              = '0;
    p.inst         = 32'h00A0_0033 + 32'(i);
    p.pc           = 32'h0000_1000 + 32'(i * 4);
    p.opa_select   = OPA_IS_RS1;
    p.opb_select   = OPB_IS_RS2;
    p.dest_reg_idx = 5'(i + 1);
    p.alu_func     = ALU_SUB;
    p.channel      = ALU;
    p.mem_size     = 3'b010;
    p.rob_tag      = 6'(i + 16);
    p.rs1_value    = 32'h1000_0000 + 32'(i);
    p.rs2_value    = 32'h2000_0000 + 32'(i);
    return p;
  endfunction

  function automatic is_packet_t exp_nop();
    is_packet_t p;
    p              = '0;
    p.inst         = 32'h0000_0013;
    p.opa_select   = OPA_IS_RS1;
    p.opb_select   = OPB_IS_RS2;
    p.dest_reg_idx = 5'd0;
    p.alu_func     = ALU_ADD;
    p.is_zeroreg   = 1'b1;
    p.channel      = ALU;
    p.mem_size     = 3'b111;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    entry_ready = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    squash = 1'b0; ex_stall = 1'b0;
    cdb_packet_in = '0;
    for (int i = 0; i < 8; i++) begin
      entry_packet_in[i] = mk_pkt(i);
      entry_flag[i] = TAGTAG;
    end
    do_reset();
    #1;
    n_cmp++; if (is_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", is_valid); end
    n_cmp++; if (is_packet_out !== exp_nop()) begin n_bad++; $display("FAIL reset_nop got=%h want=%h", is_packet_out, exp_nop()); end
    n_cmp++; if (issue_fire !== 1'b0 || clear !== 8'h00) begin n_bad++; $display("FAIL reset_idle fire=%b clear=%h want 0/00", issue_fire, clear); end
  endtask

  task automatic test_single();
    do_reset();
    entry_ready = 8'b0000_0100;
    #1;
    n_cmp++; if (clear !== 8'b0000_0100 || issue_idx !== 3'd2 || issue_fire !== 1'b1) begin
      n_bad++; $display("FAIL single_select clear=%b idx=%0d fire=%b want 00000100/2/1", clear, issue_idx, issue_fire); end
    tick();
    entry_ready = 8'b0000_1001;
    n_cmp++; if (is_valid !== 1'b1 || is_packet_out !== mk_pkt(2)) begin
      n_bad++; $display("FAIL single_packet valid=%b got=%h want=%h", is_valid, is_packet_out, mk_pkt(2)); end
    #1;
    n_cmp++; if (issue_idx !== 3'd3) begin n_bad++; $display("FAIL single_ptr idx=%0d want=3", issue_idx); end
    tick();
    entry_ready = '0;
  endtask

  task automatic test_rotation();
    do_reset();
    entry_ready = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_cmp++; if (issue_fire !== 1'b1 || issue_idx !== 3'(i % 8)) begin
        n_bad++; $display("FAIL rotate_idx cycle=%0d fire=%b idx=%0d want 1/%0d", i, issue_fire, issue_idx, i % 8); end
      if (i > 0) begin
        n_cmp++; if (is_valid !== 1'b1 || is_packet_out !== mk_pkt((i - 1) % 8)) begin
          n_bad++; $display("FAIL rotate_pkt cycle=%0d valid=%b got=%h want=%h", i, is_valid, is_packet_out, mk_pkt((i - 1) % 8)); end
      end
      tick();
    end
    entry_ready = '0;
    n_cmp++; if (is_valid !== 1'b1 || is_packet_out !== mk_pkt(0)) begin
      n_bad++; $display("FAIL rotate_last got=%h want=%h", is_packet_out, mk_pkt(0)); end
    tick();
    n_cmp++; if (is_valid !== 1'b0) begin n_bad++; $display("FAIL none_ready_drop valid=%b want=0", is_valid); end
  endtask

  task automatic test_forward();
    is_packet_t e;
    do_reset();
    entry_flag[5] = CDBCDB;
    cdb_packet_in = '{reg_tag: 6'd9, reg_value: 32'hDEAD_BEEF};
    entry_ready = 8'b0010_0000;
    #1;
    n_cmp++; if (issue_idx !== 3'd5) begin n_bad++; $display("FAIL fwd_idx idx=%0d want=5", issue_idx); end
    tick();
    e = mk_pkt(5); e.rs1_value = 32'hDEAD_BEEF; e.rs2_value = 32'hDEAD_BEEF;
    n_cmp++; if (is_packet_out !== e) begin n_bad++; $display("FAIL fwd_cdbcdb got=%h want=%h", is_packet_out, e); end
    entry_flag[6] = TAGCDB;
    cdb_packet_in = '{reg_tag: 6'd3, reg_value: 32'hCAFE_F00D};
    entry_ready = 8'b0100_0000;
    tick();
    e = mk_pkt(6); e.rs2_value = 32'hCAFE_F00D;
    n_cmp++; if (is_packet_out !== e) begin n_bad++; $display("FAIL fwd_tagcdb got=%h want=%h", is_packet_out, e); end
    entry_flag[7] = CDBTAG;
    cdb_packet_in = '{reg_tag: 6'd4, reg_value: 32'h1234_5678};
    entry_ready = 8'b1000_0000;
    tick();
    e = mk_pkt(7); e.rs1_value = 32'h1234_5678;
    n_cmp++; if (is_packet_out !== e) begin n_bad++; $display("FAIL fwd_cdbtag got=%h want=%h", is_packet_out, e); end
    entry_ready = '0;
    for (int i = 0; i < 8; i++) entry_flag[i] = TAGTAG;
    cdb_packet_in = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    entry_ready = 8'b0000_0001;
    tick();
    ex_stall = 1'b1;
    entry_ready = 8'b0000_0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (clear !== 8'h00 || issue_fire !== 1'b0 || is_valid !== 1'b1 || is_packet_out !== mk_pkt(0)) begin
        n_bad++; $display("FAIL stall_hold cycle=%0d clear=%h fire=%b valid=%b pkt=%h want 00/0/1/%h",
                          i, clear, issue_fire, is_valid, is_packet_out, mk_pkt(0)); end
      tick();
    end
    ex_stall = 1'b0;
    #1;
    n_cmp++; if (issue_fire !== 1'b1 || issue_idx !== 3'd1 || clear !== 8'b0000_0010) begin
      n_bad++; $display("FAIL stall_release fire=%b idx=%0d clear=%b want 1/1/00000010", issue_fire, issue_idx, clear); end
    tick();
    entry_ready = '0;
    n_cmp++; if (is_packet_out !== mk_pkt(1)) begin n_bad++; $display("FAIL stall_pkt got=%h want=%h", is_packet_out, mk_pkt(1)); end
    tick();
    ex_stall = 1'b1;
    entry_ready = 8'b0001_0000;
    #1;
    n_cmp++; if (issue_fire !== 1'b1 || issue_idx !== 3'd4) begin
      n_bad++; $display("FAIL stall_empty fire=%b idx=%0d want 1/4", issue_fire, issue_idx); end
    tick();
    entry_ready = '0;
    n_cmp++; if (is_valid !== 1'b1 || is_packet_out !== mk_pkt(4)) begin
      n_bad++; $display("FAIL stall_empty_pkt valid=%b got=%h want=%h", is_valid, is_packet_out, mk_pkt(4)); end
    ex_stall = 1'b0;
    tick();
  endtask

  task automatic test_squash();
    do_reset();
    entry_ready = 8'b0000_0001;
    tick();
    entry_ready = 8'b0000_1000;
    squash = 1'b1;
    #1;
    n_cmp++; if (clear !== 8'h00 || issue_fire !== 1'b0) begin
      n_bad++; $display("FAIL squash_block clear=%h fire=%b want 00/0", clear, issue_fire); end
    tick();
    squash = 1'b0;
    entry_ready = 8'b1000_0001;
    n_cmp++; if (is_valid !== 1'b0 || is_packet_out !== exp_nop()) begin
      n_bad++; $display("FAIL squash_nop valid=%b got=%h want 0/%h", is_valid, is_packet_out, exp_nop()); end
    #1;
    n_cmp++; if (issue_idx !== 3'd0 || issue_fire !== 1'b1) begin
      n_bad++; $display("FAIL squash_ptr idx=%0d fire=%b want 0/1", issue_idx, issue_fire); end
    tick();
    entry_ready = '0;
    tick();
  endtask

`ifdef ISSUE_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    n_cmp++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL perf_reset issue=%0d stall=%0d want 0/0", perf_issue_cnt, perf_stall_cnt); end
    for (int i = 0; i < 4; i++) begin
      entry_ready = 8'(1 << i);
      tick();
    end
    ex_stall = 1'b1;
    entry_ready = 8'b0010_0000;
    tick();
    tick();
    ex_stall = 1'b0;
    entry_ready = '0;
    tick();
    n_cmp++; if (perf_issue_cnt !== 32'd4 || perf_stall_cnt !== 32'd2) begin
      n_bad++; $display("FAIL perf_counts issue=%0d stall=%0d want 4/2", perf_issue_cnt, perf_stall_cnt); end
    squash = 1'b1;
    tick();
    squash = 1'b0;
    n_cmp++; if (perf_issue_cnt !== 32'd4 || perf_stall_cnt !== 32'd2) begin
      n_bad++; $display("FAIL perf_squash issue=%0d stall=%0d want 4/2", perf_issue_cnt, perf_stall_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b0; squash = 1'b0; ex_stall = 1'b0; entry_ready = '0;
    test_reset();
    test_single();
    test_rotation();
    test_forward();
    test_stall();
    test_squash();
`ifdef ISSUE_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
